// File: rtl/rr_bus_mux_if.sv
// Handshake bundle between NUM_SRC producers, the rr_bus_mux arbiter and its single consumer.
// The "slave" modport is the mux's view; "master" is the surrounding producers/consumer.
interface rr_bus_mux_if #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned NUM_SRC = 5,
  parameter int unsigned SW      = $clog2(NUM_SRC)
);

  logic [NUM_SRC*WIDTH-1:0] src_data;
  logic [NUM_SRC-1:0]       src_valid;
  logic [NUM_SRC-1:0]       src_ready;
  logic [WIDTH-1:0]         out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [SW-1:0]            out_src;
  logic [7:0]               busy_cnt;

  modport slave (
    input  src_data,
    input  src_valid,
    input  out_ready,
    output src_ready,
    output out_data,
    output out_valid,
    output out_src,
    output busy_cnt
  );

  modport master (
    output src_data,
    output src_valid,
    output out_ready,
    input  src_ready,
    input  out_data,
    input  out_valid,
    input  out_src,
    input  busy_cnt
  );

endinterface

// File: rtl/rr_bus_mux.sv
// Registered N-to-1 bus mux: arbitrates valid/ready producers (round-robin or fixed priority)
// into a single output register tagged with the winning source index.
module rr_bus_mux #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned NUM_SRC = 5,
  parameter bit          RR_EN   = 1'b1,
  parameter int unsigned SW      = $clog2(NUM_SRC)
) (
  input logic         clk,
  input logic         reset,
  rr_bus_mux_if.slave bus
);

  localparam logic [SW-1:0] LastIdx = SW'(NUM_SRC - 1);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SW-1:0]    out_src_q, out_src_d;
  logic [7:0]       busy_cnt_q, busy_cnt_d;
  logic [SW-1:0]    last_grant_q, last_grant_d;

  logic             load;
  logic             any_found, hi_found;
  logic [SW-1:0]    any_idx, hi_idx, gnt_idx;
  logic [WIDTH-1:0] gnt_data;

  // Lowest valid index overall, and lowest valid index above last_grant. In round-robin mode
  // the latter wins when present, which is exactly the wrap-around search from last_grant+1.
  always_comb begin
    any_found = 1'b0;
    hi_found  = 1'b0;
    any_idx   = '0;
    hi_idx    = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (bus.src_valid[i]) begin
        if (!any_found) begin
          any_found = 1'b1;
          any_idx   = SW'(i);
        end
        if (!hi_found && (SW'(i) > last_grant_q)) begin
          hi_found = 1'b1;
          hi_idx   = SW'(i);
        end
      end
    end
    gnt_idx = (RR_EN && hi_found) ? hi_idx : any_idx;
  end

  always_comb begin
    gnt_data = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (gnt_idx == SW'(i)) begin
        gnt_data = bus.src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign load = !out_valid_q || bus.out_ready;

  // Ready is held low during reset so no beat is consumed that the register cannot capture.
  always_comb begin
    bus.src_ready = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      bus.src_ready[i] = load && any_found && !reset && (gnt_idx == SW'(i));
    end
  end

  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_src_d    = out_src_q;
    last_grant_d = last_grant_q;
    busy_cnt_d   = busy_cnt_q;
    if (load) begin
      out_valid_d = any_found;
      if (any_found) begin
        out_data_d = gnt_data;
        out_src_d  = gnt_idx;
        if (RR_EN) begin
          last_grant_d = gnt_idx;
        end
      end
    end
    if (out_valid_q && !bus.out_ready && (busy_cnt_q != 8'hFF)) begin
      busy_cnt_d = busy_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_src_q    <= '0;
      busy_cnt_q   <= '0;
      last_grant_q <= LastIdx;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_src_q    <= out_src_d;
      busy_cnt_q   <= busy_cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_src   = out_src_q;
  assign bus.busy_cnt  = busy_cnt_q;

endmodule

// File: tb/tb_rr_bus_mux.sv
// Directed bench for rr_bus_mux: one round-robin and one fixed-priority instance, 5 x 16-bit.
module tb_rr_bus_mux;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;

  rr_bus_mux_if #(.WIDTH(16), .NUM_SRC(5)) rr ();
  rr_bus_mux_if #(.WIDTH(16), .NUM_SRC(5)) fp ();

  rr_bus_mux #(.WIDTH(16), .NUM_SRC(5), .RR_EN(1'b1)) dut_rr (
    .clk   (clk),
    .reset (reset),
    .bus   (rr)
  );

  rr_bus_mux #(.WIDTH(16), .NUM_SRC(5), .RR_EN(1'b0)) dut_fp (
    .clk   (clk),
    .reset (reset),
    .bus   (fp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Producers must hold src_valid/src_data stable across any stalled edge.
  logic        hold_q;
  logic [4:0]  valid_q;
  logic [79:0] data_q;
  always @(negedge clk) begin
    if (reset) begin
      hold_q <= 1'b0;
    end else begin
      if (hold_q) begin
        n_assert++;
        assert (rr.src_valid === valid_q && rr.src_data === data_q) else begin
          n_fail++;
          $error("FAIL src_stable: observed %h/%h expected %h/%h", rr.src_valid, rr.src_data,
                 valid_q, data_q);
        end
      end
      hold_q <= rr.out_valid & ~rr.out_ready;
    end
    valid_q <= rr.src_valid;
    data_q  <= rr.src_data;
  end

  initial begin
    n_assert     = 0;
    n_fail       = 0;
    reset        = 1'b1;
    rr.src_valid = 5'b11111;
    rr.src_data  = '0;
    rr.out_ready = 1'b0;
    fp.src_valid = 5'b00000;
    fp.src_data  = '0;
    fp.out_ready = 1'b1;

    // Reset state, with every source requesting.
    #22;
    check("rst_out_valid", 32'(rr.out_valid), 32'h0);
    check("rst_out_data", 32'(rr.out_data), 32'h0);
    check("rst_out_src", 32'(rr.out_src), 32'h0);
    check("rst_busy_cnt", 32'(rr.busy_cnt), 32'h0);
    check("rst_src_ready", 32'(rr.src_ready), 32'h0);

    // Single source after reset.
    reset        = 1'b0;
    rr.src_valid = 5'b00100;
    rr.src_data  = {16'h0000, 16'h0000, 16'h3A5C, 16'h0000, 16'h0000};
    rr.out_ready = 1'b1;
    #1;
    check("single_ready_c0", 32'(rr.src_ready), 32'h04);
    tick();
    rr.src_valid = 5'b00000;
    #1;
    check("single_valid_c1", 32'(rr.out_valid), 32'h1);
    check("single_data_c1", 32'(rr.out_data), 32'h3A5C);
    check("single_src_c1", 32'(rr.out_src), 32'h2);
    tick();
    check("single_valid_c2", 32'(rr.out_valid), 32'h0);

    // Round-robin rotation from a fresh reset.
    reset = 1'b1;
    #1;
    reset        = 1'b0;
    rr.src_valid = 5'b11111;
    rr.src_data  = {16'h4444, 16'h3333, 16'h2222, 16'h1111, 16'h0000};
    rr.out_ready = 1'b1;
    #1;
    check("rr_ready_first", 32'(rr.src_ready), 32'h01);
    for (int k = 0; k < 7; k++) begin
      tick();
      check("rr_valid", 32'(rr.out_valid), 32'h1);
      check("rr_src", 32'(rr.out_src), 32'(k % 5));
      check("rr_data", 32'(rr.out_data), 32'((k % 5) * 16'h1111));
      check("rr_ready", 32'(rr.src_ready), 32'(1 << ((k + 1) % 5)));
    end

    // Back-pressure holding BEEF from source 1 while sources 0 and 3 wait.
    reset = 1'b1;
    #1;
    reset        = 1'b0;
    rr.src_valid = 5'b00010;
    rr.src_data  = {16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000};
    rr.out_ready = 1'b1;
    #1;
    check("bp_ready_load", 32'(rr.src_ready), 32'h02);
    tick();
    check("bp_src_loaded", 32'(rr.out_src), 32'h1);
    check("bp_data_loaded", 32'(rr.out_data), 32'hBEEF);
    rr.out_ready = 1'b0;
    rr.src_valid = 5'b01001;
    rr.src_data  = {16'h0000, 16'h0D0D, 16'h0000, 16'hBEEF, 16'h0A0A};
    #1;
    check("bp_ready_stall0", 32'(rr.src_ready), 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("bp_ready_stall", 32'(rr.src_ready), 32'h0);
      check("bp_data_hold", 32'(rr.out_data), 32'hBEEF);
      check("bp_valid_hold", 32'(rr.out_valid), 32'h1);
      check("bp_busy_cnt", 32'(rr.busy_cnt), 32'(k + 1));
    end
    rr.out_ready = 1'b1;
    #1;
    check("bp_ready_release", 32'(rr.src_ready), 32'h08);
    tick();
    check("bp_src_next", 32'(rr.out_src), 32'h3);
    check("bp_data_next", 32'(rr.out_data), 32'h0D0D);
    check("bp_busy_final", 32'(rr.busy_cnt), 32'h4);
    rr.src_valid = 5'b00000;
    tick();
    check("bp_drain", 32'(rr.out_valid), 32'h0);

    // Fixed priority: source 1 starves source 4 until it drops.
    fp.src_valid = 5'b10010;
    fp.src_data  = {16'h0044, 16'h0000, 16'h0000, 16'h0011, 16'h0000};
    #1;
    check("fp_ready_first", 32'(fp.src_ready), 32'h02);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("fp_src", 32'(fp.out_src), 32'h1);
      check("fp_data", 32'(fp.out_data), 32'h0011);
      check("fp_ready", 32'(fp.src_ready), 32'h02);
    end
    fp.src_valid = 5'b10000;
    #1;
    check("fp_ready_drop", 32'(fp.src_ready), 32'h10);
    tick();
    check("fp_src_after", 32'(fp.out_src), 32'h4);
    check("fp_data_after", 32'(fp.out_data), 32'h0044);
    fp.src_valid = 5'b00000;

    // Wrap: last grant 4, sources 0 and 3 valid -> 0 first.
    rr.src_valid = 5'b10000;
    rr.src_data  = {16'h4444, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    #1;
    check("wrap_ready4", 32'(rr.src_ready), 32'h10);
    tick();
    check("wrap_src4", 32'(rr.out_src), 32'h4);
    rr.src_valid = 5'b01001;
    rr.src_data  = {16'h0000, 16'h0D0D, 16'h0000, 16'h0000, 16'h0ABC};
    #1;
    check("wrap_ready0", 32'(rr.src_ready), 32'h01);
    tick();
    check("wrap_src0", 32'(rr.out_src), 32'h0);
    check("wrap_data0", 32'(rr.out_data), 32'h0ABC);

    // Saturation: busy_cnt starts at 4 and stalls 300 cycles.
    rr.out_ready = 1'b0;
    #1;
    check("sat_ready_stall", 32'(rr.src_ready), 32'h0);
    for (int k = 0; k < 250; k++) tick();
    check("sat_busy_254", 32'(rr.busy_cnt), 32'd254);
    tick();
    check("sat_busy_255", 32'(rr.busy_cnt), 32'd255);
    for (int k = 0; k < 49; k++) tick();
    check("sat_busy_hold", 32'(rr.busy_cnt), 32'd255);
    check("sat_data_hold", 32'(rr.out_data), 32'h0ABC);

    // Async reset mid-stream.
    rr.out_ready = 1'b1;
    #1;
    check("ar_ready_release", 32'(rr.src_ready), 32'h08);
    tick();
    check("ar_src3", 32'(rr.out_src), 32'h3);
    rr.src_valid = 5'b11111;
    rr.src_data  = {16'h4444, 16'h3333, 16'h2222, 16'h1111, 16'h5A5A};
    #1;
    check("ar_valid_pre", 32'(rr.out_valid), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_out_valid", 32'(rr.out_valid), 32'h0);
    check("ar_out_data", 32'(rr.out_data), 32'h0);
    check("ar_busy_cnt", 32'(rr.busy_cnt), 32'h0);
    check("ar_out_src", 32'(rr.out_src), 32'h0);
    check("ar_src_ready", 32'(rr.src_ready), 32'h0);
    #1;
    reset = 1'b0;
    #1;
    check("ar_ready_first", 32'(rr.src_ready), 32'h01);
    tick();
    check("ar_src_first", 32'(rr.out_src), 32'h0);
    check("ar_data_first", 32'(rr.out_data), 32'h5A5A);
    tick();
    check("ar_src_second", 32'(rr.out_src), 32'h1);
    check("ar_data_second", 32'(rr.out_data), 32'h1111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
